// File: rtl/logical_unit_pipe_pkg.sv
// Shared definitions for the pipelined logical unit.
// Contents:
//   logic_op_e      - 3-bit logic_type op codes; bit 2 selects the immediate form.
//   IMM_SEL_BIT     - index of the immediate-select bit within the op code.
//   is_reserved_op  - flags the two reserved op codes (011, 111).
package logical_unit_pipe_pkg;

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_RSV_3 = 3'b011,
    OP_ANDI  = 3'b100,
    OP_ORI   = 3'b101,
    OP_XORI  = 3'b110,
    OP_RSV_7 = 3'b111
  } logic_op_e;

  localparam int IMM_SEL_BIT = 2;

  function automatic logic is_reserved_op(input logic [2:0] op);
    return (op == OP_RSV_3) || (op == OP_RSV_7);
  endfunction

endpackage

// File: rtl/logical_unit_pipe_stage.sv
// One elastic pipeline stage: a valid bit plus a WIDTH-bit payload register.
// Ports:
//   clk, reset      - rising-edge clock, asynchronous active-high reset
//   i_flush         - clear the valid bit at the next edge (beats i_load)
//   i_load          - capture i_valid/i_data at the next edge
//   i_valid, i_data - contents offered by the upstream stage
//   o_valid, o_data - registered stage contents
module pipe_stage_elastic #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_load,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // NOTE: sequential state is written with non-blocking assignments so every
  // stage samples its neighbour's pre-edge value and the chain shifts by one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      // A bubble from upstream loads too; that is how gaps collapse.
      r_valid <= i_valid;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/logical_unit_pipe.sv
// Pipelined, elastic AND/OR/XOR(+immediate) unit between issue and writeback.
// The result is computed at the input and carried with its tag and illegal
// flag through STAGES elastic registers; stage STAGES drives out_*.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   in_valid/in_ready          - issue-side handshake
//   in_op, in_src1, in_src2    - op code and register operands
//   in_imm, in_tag             - raw immediate (sign-extended) and uop tag
//   flush                      - drop every in-flight uop and the current input
//   out_valid/out_ready        - writeback-side handshake
//   out_result, out_tag        - result and its tag
//   out_illegal                - uop carried a reserved op code
//   inflight                   - number of valid uops held in the pipe
module logical_unit_pipe
  import logical_unit_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 12,
  parameter int TAG_WIDTH  = 6,
  parameter int STAGES     = 2,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_src1,
  input  logic [DATA_WIDTH-1:0] in_src2,
  input  logic [IMM_WIDTH-1:0]  in_imm,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_illegal,
  output logic [CNT_WIDTH-1:0]  inflight
);

  localparam int PW = 1 + TAG_WIDTH + DATA_WIDTH;  // {illegal, tag, result}

  logic [DATA_WIDTH-1:0] w_imm_ext;
  logic [DATA_WIDTH-1:0] w_op2;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_illegal;
  logic [STAGES:0]       w_valid;   // index 0 is the issue-side input
  logic [PW-1:0]         w_data [0:STAGES];
  logic [STAGES:1]       w_load;
  logic                  w_in_fire;
  logic                  w_out_fire;
  logic [CNT_WIDTH-1:0]  r_inflight;

  if (IMM_WIDTH == DATA_WIDTH) begin : g_imm_full
    assign w_imm_ext = in_imm;
  end else begin : g_imm_sext
    assign w_imm_ext = {{(DATA_WIDTH-IMM_WIDTH){in_imm[IMM_WIDTH-1]}}, in_imm};
  end

  assign w_op2 = in_op[IMM_SEL_BIT] ? w_imm_ext : in_src2;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    w_result  = '0;
    w_illegal = is_reserved_op(in_op);
    case (logic_op_e'(in_op))
      OP_AND, OP_ANDI: w_result = in_src1 & w_op2;
      OP_OR,  OP_ORI:  w_result = in_src1 | w_op2;
      OP_XOR, OP_XORI: w_result = in_src1 ^ w_op2;
      default:         w_result = '0;
    endcase
  end

  // Ready chain, walked from the output back to the input: a stage may load
  // when it is empty or when its contents leave in the same cycle.
  always_comb begin
    logic adv;
    w_load = '0;
    adv    = out_ready;
    for (int k = STAGES; k >= 1; k--) begin
      w_load[k] = !w_valid[k] || adv;
      adv       = w_load[k];
    end
  end

  assign w_valid[0] = in_valid;
  assign w_data[0]  = {w_illegal, in_tag, w_result};

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    pipe_stage_elastic #(.WIDTH(PW)) u_stage (
      .clk     (clk),
      .reset   (reset),
      .i_flush (flush),
      .i_load  (w_load[k]),
      .i_valid (w_valid[k-1]),
      .i_data  (w_data[k-1]),
      .o_valid (w_valid[k]),
      .o_data  (w_data[k])
    );
  end

  assign in_ready   = w_load[1];
  assign out_valid  = w_valid[STAGES];
  assign {out_illegal, out_tag, out_result} = w_data[STAGES];

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inflight <= '0;
    end else if (flush) begin
      r_inflight <= '0;
    end else if (w_in_fire && !w_out_fire) begin
      r_inflight <= r_inflight + CNT_WIDTH'(1);
    end else if (!w_in_fire && w_out_fire) begin
      r_inflight <= r_inflight - CNT_WIDTH'(1);
    end
  end

  assign inflight = r_inflight;

endmodule

// File: tb/tb_logical_unit_pipe.sv
// Directed bench for logical_unit_pipe with default parameters (STAGES=2).
module tb_logical_unit_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic [11:0] in_imm;
  logic [5:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [5:0]  out_tag;
  logic        out_illegal;
  logic [2:0]  inflight;

  int n_vec  = 0;
  int n_miss = 0;

  logic [2:0]  s_op   [8];
  logic [31:0] s_src1 [8];
  logic [31:0] s_src2 [8];
  logic [31:0] s_exp  [8];

  logical_unit_pipe dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_src1     (in_src1),
    .in_src2     (in_src2),
    .in_imm      (in_imm),
    .in_tag      (in_tag),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_tag     (out_tag),
    .out_illegal (out_illegal),
    .inflight    (inflight)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [11:0] imm, input logic [5:0] tag);
    in_valid = v;
    in_op    = op;
    in_src1  = s1;
    in_src2  = s2;
    in_imm   = imm;
    in_tag   = tag;
  endtask

  task automatic check_out(input string name, input logic v, input logic [31:0] res,
                           input logic [5:0] tag, input logic ill);
    check({name, ".valid"},   out_valid,   v);
    check({name, ".result"},  out_result,  res);
    check({name, ".tag"},     out_tag,     tag);
    check({name, ".illegal"}, out_illegal, ill);
  endtask

  initial begin
    s_op[0] = 3'b000; s_src1[0] = 32'hA5A5_A5A5; s_src2[0] = 32'h0F0F_0F0F; s_exp[0] = 32'h0505_0505;
    s_op[1] = 3'b001; s_src1[1] = 32'h1111_0000; s_src2[1] = 32'h0000_1111; s_exp[1] = 32'h1111_1111;
    s_op[2] = 3'b010; s_src1[2] = 32'hFFFF_0000; s_src2[2] = 32'h0F0F_0F0F; s_exp[2] = 32'hF0F0_0F0F;
    s_op[3] = 3'b000; s_src1[3] = 32'hFFFF_FFFF; s_src2[3] = 32'h1234_5678; s_exp[3] = 32'h1234_5678;
    s_op[4] = 3'b001; s_src1[4] = 32'h8000_0000; s_src2[4] = 32'h0000_0001; s_exp[4] = 32'h8000_0001;
    s_op[5] = 3'b010; s_src1[5] = 32'hAAAA_AAAA; s_src2[5] = 32'h5555_5555; s_exp[5] = 32'hFFFF_FFFF;
    s_op[6] = 3'b000; s_src1[6] = 32'h0000_FFFF; s_src2[6] = 32'h00FF_00FF; s_exp[6] = 32'h0000_00FF;
    s_op[7] = 3'b010; s_src1[7] = 32'h1234_5678; s_src2[7] = 32'h1234_5678; s_exp[7] = 32'h0000_0000;

    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 3'b000, '0, '0, '0, '0);

    // Reset state
    step();
    step();
    check_out("rst", 1'b0, 32'h0, 6'd0, 1'b0);
    check("rst.inflight", inflight, 3'd0);
    reset = 1'b0;
    #1;
    check("rst.in_ready", in_ready, 1'b1);

    // XORI latency: visible after the second edge
    drive(1'b1, 3'b110, 32'h0000_00FF, '0, 12'hFFF, 6'd5);
    step();
    in_valid = 1'b0;
    check("xori.early_valid", out_valid, 1'b0);
    check("xori.inflight1", inflight, 3'd1);
    step();
    check_out("xori", 1'b1, 32'hFFFF_FF00, 6'd5, 1'b0);
    step();
    check("xori.drained", inflight, 3'd0);

    // ANDI then ORI with a negative immediate
    drive(1'b1, 3'b100, 32'h1234_5678, '0, 12'h0F0, 6'd1);
    step();
    drive(1'b1, 3'b101, 32'h0000_0000, '0, 12'h800, 6'd2);
    step();
    in_valid = 1'b0;
    check_out("andi", 1'b1, 32'h0000_0070, 6'd1, 1'b0);
    step();
    check_out("ori_sext", 1'b1, 32'hFFFF_F800, 6'd2, 1'b0);
    step();

    // Eight back-to-back uops at full throughput
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        drive(1'b1, s_op[i], s_src1[i], s_src2[i], 12'h000, 6'(10 + i));
        check($sformatf("stream.in_ready%0d", i), in_ready, 1'b1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i >= 1)
        check_out($sformatf("stream%0d", i - 1), 1'b1, s_exp[i-1], 6'(10 + i - 1), 1'b0);
    end
    step();
    check("stream.empty", out_valid, 1'b0);

    // Backpressure: in_ready drops after exactly two accepts, outputs hold
    out_ready = 1'b0;
    drive(1'b1, 3'b001, 32'h1, 32'h2, '0, 6'd20);
    check("bp.ready0", in_ready, 1'b1);
    step();
    check("bp.inflight1", inflight, 3'd1);
    drive(1'b1, 3'b010, 32'hF0, 32'hFF, '0, 6'd21);
    check("bp.ready1", in_ready, 1'b1);
    step();
    check("bp.inflight2", inflight, 3'd2);
    drive(1'b1, 3'b000, 32'hFF, 32'h3C, '0, 6'd22);
    check("bp.ready_full", in_ready, 1'b0);
    check_out("bp.head", 1'b1, 32'h3, 6'd20, 1'b0);
    step();
    check("bp.inflight_hold", inflight, 3'd2);
    check_out("bp.hold1", 1'b1, 32'h3, 6'd20, 1'b0);
    step();
    check_out("bp.hold2", 1'b1, 32'h3, 6'd20, 1'b0);
    out_ready = 1'b1;
    #1;
    check("bp.ready_release", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check_out("bp.drain21", 1'b1, 32'h0F, 6'd21, 1'b0);
    check("bp.inflight_swap", inflight, 3'd2);
    step();
    check_out("bp.drain22", 1'b1, 32'h3C, 6'd22, 1'b0);
    check("bp.inflight_dec", inflight, 3'd1);
    step();
    check("bp.empty", out_valid, 1'b0);
    check("bp.inflight0", inflight, 3'd0);

    // Flush a full pipe, then flush with an acceptable input
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'hFFFF_FFFF, 32'h30, '0, 6'd30);
    step();
    drive(1'b1, 3'b000, 32'hFFFF_FFFF, 32'h31, '0, 6'd31);
    step();
    check("fl.inflight_full", inflight, 3'd2);
    drive(1'b1, 3'b000, 32'hFFFF_FFFF, 32'h32, '0, 6'd32);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl.inflight0", inflight, 3'd0);
    check("fl.valid0", out_valid, 1'b0);
    drive(1'b1, 3'b001, 32'h0, 32'h33, '0, 6'd33);
    flush = 1'b1;
    check("fl.ready_empty", in_ready, 1'b1);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("fl.dropped_cnt", inflight, 3'd0);
    step();
    check("fl.dropped_out1", out_valid, 1'b0);
    step();
    check("fl.dropped_out2", out_valid, 1'b0);

    // Reserved op codes
    drive(1'b1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 12'hFFF, 6'd9);
    step();
    drive(1'b1, 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 12'hFFF, 6'd11);
    step();
    in_valid = 1'b0;
    check_out("ill011", 1'b1, 32'h0, 6'd9, 1'b1);
    step();
    check_out("ill111", 1'b1, 32'h0, 6'd11, 1'b1);
    step();

    // Asynchronous reset between edges with a full pipe
    out_ready = 1'b0;
    drive(1'b1, 3'b010, 32'h1234_5678, 32'hFFFF_0000, '0, 6'd40);
    step();
    step();
    check("ar.full", inflight, 3'd2);
    #2;
    reset = 1'b1;
    #1;
    check_out("ar", 1'b0, 32'h0, 6'd0, 1'b0);
    check("ar.inflight", inflight, 3'd0);
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    #1;
    check("ar.in_ready", in_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/logical_unit_pipe.md
Name: logical_unit_pipe

Overview:
- Parametrised, elastic, pipelined successor to the single-cycle logical unit in the integer execution cluster.
- Executes AND/OR/XOR and the immediate forms ANDI/ORI/XORI.
- Register and immediate operands are DATA_WIDTH wide; the immediate is sign-extended to DATA_WIDTH.
- Adds valid/ready handshakes on both sides, an instruction tag, illegal-op flagging, flush, and an in-flight occupancy count.
- Sits between issue and writeback arbitration.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- IMM_WIDTH, 12, raw immediate width; sign-extended to DATA_WIDTH; legal range 1..DATA_WIDTH.
- TAG_WIDTH, 6, ROB/destination tag carried alongside each uop.
- STAGES, 2, pipeline depth = issue-to-result latency in cycles; legal range 1..4.
- CNT_WIDTH, 3, width of inflight; must satisfy 2^CNT_WIDTH > STAGES.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- in_valid, input, 1, uop presented.
- in_ready, output, 1, unit can accept a uop this cycle.
- in_op, input, 3, logic_type code; bit 2 = immediate select.
- in_src1, input, DATA_WIDTH, rs1 value.
- in_src2, input, DATA_WIDTH, rs2 value.
- in_imm, input, IMM_WIDTH, raw immediate.
- in_tag, input, TAG_WIDTH, uop tag.
- flush, input, 1, kill all in-flight uops.
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer accepts the result.
- out_result, output, DATA_WIDTH, logical result.
- out_tag, output, TAG_WIDTH, tag of out_result.
- out_illegal, output, 1, uop carried a reserved op code.
- inflight, output, CNT_WIDTH, number of valid uops held in the pipe.

Behaviour:
- Op codes:
  - 000 AND, 001 OR, 010 XOR.
  - 100 ANDI, 101 ORI, 110 XORI.
  - 011 and 111 are reserved: result 0, illegal=1.
- Operand 2 = sign_ext(in_imm) when in_op[2]=1, else in_src2.
- Result is computed combinationally at the input from in_* and captured into stage 1 on an accepted uop. Stages 2..STAGES are pure elastic registers.
- Each stage holds {valid, result, tag, illegal}. out_* is driven by stage STAGES.
- Per-stage advance rule:
  - Stage k loads when stage k is empty, or when stage k's contents move on in the same cycle (k<STAGES: stage k+1 loads; k=STAGES: out_ready=1).
  - in_ready equals stage 1's load condition. This gives full throughput of 1 uop/cycle with out_ready held high.
  - There is no combinational path from in_valid to out_valid.
  - in_ready depends combinationally on out_ready through the ready chain; this is accepted for STAGES≤4.
- Latency: a uop accepted at edge N appears with out_valid=1 after edge N+STAGES-1, provided nothing stalls. With STAGES=1 it is visible the cycle after acceptance.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_result, out_tag and out_illegal hold stable.
  - Bubbles collapse: upstream stages keep filling until the pipe is full. A full pipe deasserts in_ready.
- Handshake rules:
  - A transfer occurs only when valid and ready are both 1 at a rising edge.
  - in_valid with in_ready=0 is not consumed; the source holds its data.
- Flush:
  - Synchronous. At the next edge all valid bits clear and inflight becomes 0.
  - A uop presented in a flush cycle is dropped, even if in_ready=1.
  - An output handshake in the flush cycle still completes.
  - Flush has priority over every load.
- inflight:
  - Registered count of set valid bits.
  - +1 on an accepted input, -1 on an output transfer, unchanged when both occur; 0 after flush.
  - Never exceeds STAGES.
- Reset (asynchronous assert; release is synchronous to clk at the integration level):
  - All valid bits = 0, data/tag/illegal registers = 0.
  - out_valid=0, out_result=0, out_tag=0, out_illegal=0, inflight=0.
  - in_ready=1 once reset deasserts.
  - Reset mid-stream discards all in-flight uops immediately, without waiting for the next clock edge.
- Width rules:
  - Bitwise ops only; no carry, no overflow.
  - Sign extension replicates in_imm[IMM_WIDTH-1].
  - IMM_WIDTH=DATA_WIDTH means no extension.

Decomposition:
- Shared package/header (alongside the existing execution params): op code constants AND/OR/XOR/ANDI/ORI/XORI, the immediate-select bit index (bit 2), and the reserved-code list.
- One natural sub-module, pipe_stage_elastic: one valid+payload register with load/advance/flush logic, parametrised by payload width. It is instantiated STAGES times via generate.

Test Plan:
- Reset, then STAGES=2, out_ready=1, XORI src1=0x0000_00FF imm=0xFFF (tag 5) → out_valid after 2 edges, out_result=0xFFFF_FF00, tag=5, illegal=0.
- ANDI src1=0x1234_5678 imm=0x0F0 → 0x0000_0070; ORI imm=0x800 on src1=0 → 0xFFFF_F800 (sign extension).
- Stream 8 back-to-back AND/OR/XOR uops with out_ready=1 → 8 results on 8 consecutive cycles, tags in order, in_ready constantly 1.
- Hold out_ready=0 while streaming → in_ready drops after exactly STAGES accepts, inflight=STAGES, out_* stable. Release → drains in order with no loss or duplication.
- Pipe full (inflight=2) and flush asserted with in_valid=1 → next cycle inflight=0, out_valid=0, flushed-cycle input never appears.
- Op 3'b011 with tag 9 → out_result=0, out_illegal=1, tag=9. Assert reset mid-stream between edges → outputs zero immediately, inflight=0.
